// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end for the 5-stage RV32 core. Owns the fetch PC,
// issues word-aligned requests to instruction memory over a request/grant
// port, collects in-order responses into a small instruction queue and
// presents {pc, instr} to decode with valid/ready backpressure. A redirect
// from execute flushes the queue and arranges for every response still in
// flight to be discarded when it returns.
//
// Parameters
//   RESET_PC        fetch PC loaded on reset (low two bits forced to zero)
//   DEPTH           queue entries, power of two >= 2; also the limit on
//                   queued + outstanding requests
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           asynchronous active-high reset
//   iaddr   [31:0]  request address (always word aligned)
//   ireq            request valid
//   iready          memory accepts the request this cycle
//   idata   [31:0]  response instruction word
//   ivalid          response valid (in issue order, latency >= 1)
//   redirect_valid  taken branch / jump from execute
//   redirect_pc     redirect target
//   id_valid        queue head valid toward decode
//   id_pc   [31:0]  PC of the head instruction (0 when empty)
//   id_instr[31:0]  head instruction word (0 when empty)
//   id_ready        decode accepts the head this cycle
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ireq,
  input  logic        iready,
  input  logic [31:0] idata,
  input  logic        ivalid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] ONE_P    = PW'(1);
  localparam logic [31:0]   RESET_WA = {RESET_PC[31:2], 2'b00};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_q_instr [DEPTH];

  // ---------------------------------------------------------------------
  // Next-state / control wires
  // ---------------------------------------------------------------------
  logic [31:0]   w_fetch_pc_next;
  logic [31:0]   w_resp_pc_next;
  logic [PW-1:0] w_rd_ptr_next;
  logic [PW-1:0] w_wr_ptr_next;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_outstanding_next;
  logic [CW-1:0] w_drop_next;
  logic [CW-1:0] w_out_after_resp;
  logic [CW:0]   w_credit_used;
  logic [31:0]   w_redirect_wa;
  logic          w_issue;
  logic          w_pop;
  logic          w_push;
  logic          w_discard;
  logic          w_unused_lsbs;

  // The low target bits are dropped by word alignment.
  assign w_unused_lsbs = ^redirect_pc[1:0];
  assign w_redirect_wa = {redirect_pc[31:2], 2'b00};

  // Credit: every queued entry and every in-flight request holds one slot,
  // so a returning response always finds room in the queue.
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};

  assign iaddr   = r_fetch_pc;
  assign ireq    = !reset && !redirect_valid && (w_credit_used < DEPTH_W);
  assign w_issue = ireq && iready;

  // No bypass: a response is visible to decode only after it is queued.
  assign id_valid = (r_count != '0);
  assign id_pc    = id_valid ? r_q_pc[r_rd_ptr]    : 32'h0;
  assign id_instr = id_valid ? r_q_instr[r_rd_ptr] : 32'h0;

  assign w_pop     = id_valid && id_ready && !redirect_valid;
  assign w_discard = ivalid && (r_drop != '0);
  assign w_push    = ivalid && (r_drop == '0) && !redirect_valid;

  // Outstanding count after retiring this cycle's response, never below 0.
  assign w_out_after_resp = (ivalid && (r_outstanding != '0))
                          ? (r_outstanding - ONE_C) : r_outstanding;

  always_comb begin
    w_fetch_pc_next    = r_fetch_pc;
    w_resp_pc_next     = r_resp_pc;
    w_rd_ptr_next      = r_rd_ptr;
    w_wr_ptr_next      = r_wr_ptr;
    w_count_next       = r_count;
    w_outstanding_next = r_outstanding;
    w_drop_next        = r_drop;

    if (redirect_valid) begin
      // Redirect wins over every other update. After it, every request
      // still in flight is stale (including any already marked for drop),
      // so the drop count becomes exactly the remaining outstanding count.
      // This keeps drop <= outstanding across back-to-back redirects.
      w_fetch_pc_next    = w_redirect_wa;
      w_resp_pc_next     = w_redirect_wa;
      w_rd_ptr_next      = '0;
      w_wr_ptr_next      = '0;
      w_count_next       = '0;
      w_outstanding_next = w_out_after_resp;
      w_drop_next        = w_out_after_resp;
    end else begin
      if (w_issue) begin
        w_fetch_pc_next = r_fetch_pc + 32'd4;
      end

      unique case ({w_issue, ivalid})
        2'b10:   w_outstanding_next = r_outstanding + ONE_C;
        2'b01:   w_outstanding_next = w_out_after_resp;
        default: w_outstanding_next = r_outstanding;
      endcase

      if (w_discard) begin
        w_drop_next = r_drop - ONE_C;
      end

      if (w_push) begin
        w_resp_pc_next = r_resp_pc + 32'd4;
        w_wr_ptr_next  = r_wr_ptr + ONE_P;
      end

      if (w_pop) begin
        w_rd_ptr_next = r_rd_ptr + ONE_P;
      end

      unique case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + ONE_C;
        2'b01:   w_count_next = r_count - ONE_C;
        default: w_count_next = r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_WA;
      r_resp_pc     <= RESET_WA;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_next;
      r_resp_pc     <= w_resp_pc_next;
      r_rd_ptr      <= w_rd_ptr_next;
      r_wr_ptr      <= w_wr_ptr_next;
      r_count       <= w_count_next;
      r_outstanding <= w_outstanding_next;
      r_drop        <= w_drop_next;
    end
  end

  // Queue storage needs no reset: entries are only read while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
      r_q_instr[r_wr_ptr] <= idata;
    end
  end

  // ---------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------
  a_resp_has_request: assert property (
    @(posedge clk) disable iff (reset) ivalid |-> (r_outstanding != '0));

  a_iaddr_aligned: assert property (
    @(posedge clk) disable iff (reset) iaddr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage: a hand-derived vector table for the
// streaming / backpressure / grant-stall / redirect / wrap sequences, a few
// hand-written multi-cycle corner cases, then randomized traffic checked
// every cycle against a request-level reference model (in-flight requests
// tagged stale on redirect, queue of {pc, instr}).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk;
  logic        reset;
  logic [31:0] iaddr;
  logic        ireq;
  logic        iready;
  logic [31:0] idata;
  logic        ivalid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .iaddr          (iaddr),
    .ireq           (ireq),
    .iready         (iready),
    .idata          (idata),
    .ivalid         (ivalid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_ready       (id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h required %08h", nm, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_0000;
  endfunction

  // ---------------- memory environment ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  bit    mem_hold;
  int    lat_min;
  int    lat_max;
  int    cyc = 0;

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  ent_t        m_q[$];
  req_t        m_fl[$];
  logic [31:0] m_fetch = RESET_PC;
  bit          e_ireq;
  bit          e_idv;
  logic [31:0] e_pc;
  logic [31:0] e_instr;

  // Drive memory response, let the DUT settle, compare against the model.
  task automatic settle();
    if (reset) begin
      mem_q.delete();
      m_q.delete();
      m_fl.delete();
      m_fetch = {RESET_PC[31:2], 2'b00};
    end
    ivalid = 1'b0;
    idata  = $urandom;
    if (!reset && !mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      ivalid = 1'b1;
      idata  = mem_word(mem_q[0].addr);
    end
    #1;
    e_ireq  = !reset && !redirect_valid && ((m_q.size() + m_fl.size()) < DEPTH);
    e_idv   = (m_q.size() != 0);
    e_pc    = e_idv ? m_q[0].pc    : 32'h0;
    e_instr = e_idv ? m_q[0].instr : 32'h0;
    chk("model_ireq",     32'(ireq),     32'(e_ireq));
    chk("model_iaddr",    iaddr,         m_fetch);
    chk("model_id_valid", 32'(id_valid), 32'(e_idv));
    chk("model_id_pc",    id_pc,         e_pc);
    chk("model_id_instr", id_instr,      e_instr);
  endtask

  // Sample pre-edge, take the clock edge, update memory and model.
  task automatic finish_cycle();
    bit          s_rst, s_issue, s_redir, s_ivalid, s_pop_m, s_ireq_m;
    logic [31:0] s_iaddr, s_idata, s_rpc;
    req_t        r;
    int          due;
    s_rst    = reset;
    s_issue  = ireq && iready;
    s_iaddr  = iaddr;
    s_ivalid = ivalid;
    s_idata  = idata;
    s_redir  = redirect_valid;
    s_rpc    = redirect_pc;
    s_pop_m  = !s_rst && !s_redir && e_idv && id_ready;
    s_ireq_m = e_ireq && iready;
    if (!s_rst && id_valid && id_ready && !s_redir)
      $display("pop   cyc=%0d pc=%08h instr=%08h", cyc, id_pc, id_instr);
    @(posedge clk);
    if (s_ivalid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (!s_rst && s_issue) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (mem_q.size() > 0 && mem_q[$].due > due) due = mem_q[$].due;
      mem_q.push_back('{addr: s_iaddr, due: due});
    end
    if (!s_rst) begin
      if (s_redir) begin
        m_q.delete();
        if (s_ivalid && m_fl.size() > 0) void'(m_fl.pop_front());
        foreach (m_fl[k]) m_fl[k].stale = 1'b1;
        m_fetch = {s_rpc[31:2], 2'b00};
      end else begin
        if (s_pop_m && m_q.size() > 0) void'(m_q.pop_front());
        if (s_ivalid && m_fl.size() > 0) begin
          r = m_fl.pop_front();
          if (!r.stale) m_q.push_back('{pc: r.addr, instr: s_idata});
        end
        if (s_ireq_m) begin
          m_fl.push_back('{addr: m_fetch, stale: 1'b0});
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    finish_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst; bit ir; bit dr; bit rv; logic [31:0] rpc;
    bit x_ireq; logic [31:0] x_iaddr; bit x_idv; logic [31:0] x_pc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, input bit ir, input bit dr, input bit rv,
                     input logic [31:0] rpc, input bit x_ireq,
                     input logic [31:0] x_iaddr, input bit x_idv,
                     input logic [31:0] x_pc);
    tbl.push_back('{rst: rst, ir: ir, dr: dr, rv: rv, rpc: rpc,
                    x_ireq: x_ireq, x_iaddr: x_iaddr, x_idv: x_idv, x_pc: x_pc});
  endtask

  initial begin
    bit found;
    reset = 1'b1; iready = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    ivalid = 1'b0; idata = 32'h0;
    mem_hold = 1'b0; lat_min = 1; lat_max = 1;
    @(negedge clk);

    //   rst ir dr rv rpc            ireq iaddr         idv pc
    add(1, 1, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0);
    add(1, 1, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          1, 32'h0,         0, 32'h0);  // stream
    add(0, 1, 1, 0, 32'h0,          1, 32'h4,         0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h8,         1, 32'h0);
    add(0, 1, 1, 0, 32'h0,          1, 32'h8,         1, 32'h4);
    add(0, 1, 1, 0, 32'h0,          1, 32'hC,         0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h10,        1, 32'h8);
    add(0, 1, 1, 0, 32'h0,          1, 32'h10,        1, 32'hC);
    add(0, 1, 0, 0, 32'h0,          1, 32'h14,        0, 32'h0);  // backpressure
    add(0, 1, 0, 0, 32'h0,          0, 32'h18,        1, 32'h10);
    add(0, 1, 0, 0, 32'h0,          0, 32'h18,        1, 32'h10);
    add(0, 1, 0, 0, 32'h0,          0, 32'h18,        1, 32'h10);
    add(0, 1, 1, 0, 32'h0,          0, 32'h18,        1, 32'h10);
    add(0, 1, 1, 0, 32'h0,          1, 32'h18,        1, 32'h14);
    add(0, 1, 1, 0, 32'h0,          1, 32'h1C,        0, 32'h0);
    add(0, 0, 1, 0, 32'h0,          0, 32'h20,        1, 32'h18); // grant stall
    add(0, 0, 1, 0, 32'h0,          1, 32'h20,        1, 32'h1C);
    add(0, 0, 1, 0, 32'h0,          1, 32'h20,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          1, 32'h20,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          1, 32'h24,        0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h28,        1, 32'h20);
    add(0, 1, 1, 0, 32'h0,          1, 32'h28,        1, 32'h24);
    add(0, 1, 1, 1, 32'h103,        0, 32'h2C,        0, 32'h0);  // redirect
    add(0, 1, 1, 0, 32'h0,          1, 32'h100,       0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          1, 32'h104,       0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h108,       1, 32'h100);
    add(0, 1, 1, 1, 32'hFFFF_FFFE,  0, 32'h108,       1, 32'h104);
    add(0, 1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0);  // wrap
    add(0, 1, 1, 0, 32'h0,          1, 32'h0,         0, 32'h0);
    add(0, 1, 1, 0, 32'h0,          0, 32'h4,         1, 32'hFFFF_FFFC);
    add(0, 1, 1, 0, 32'h0,          1, 32'h4,         1, 32'h0);

    foreach (tbl[i]) begin
      reset          = tbl[i].rst;
      iready         = tbl[i].ir;
      id_ready       = tbl[i].dr;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      settle();
      chk($sformatf("vec%0d_ireq", i),     32'(ireq),     32'(tbl[i].x_ireq));
      chk($sformatf("vec%0d_iaddr", i),    iaddr,         tbl[i].x_iaddr);
      chk($sformatf("vec%0d_id_valid", i), 32'(id_valid), 32'(tbl[i].x_idv));
      chk($sformatf("vec%0d_id_pc", i),    id_pc,         tbl[i].x_pc);
      chk($sformatf("vec%0d_id_instr", i), id_instr,
          tbl[i].x_idv ? mem_word(tbl[i].x_pc) : 32'h0);
      finish_cycle();
    end
    redirect_valid = 1'b0;

    // Redirect with two requests in flight: both stale words are dropped.
    iready = 1'b1; id_ready = 1'b1;
    do_reset();
    mem_hold = 1'b1;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0; mem_hold = 1'b0;
    settle();
    chk("inflight_flush_empty", 32'(id_valid), 32'h0);
    chk("inflight_credit_held", 32'(ireq),     32'h0);
    finish_cycle();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      settle();
      if (id_valid) begin
        found = 1'b1;
        chk("inflight_first_pc", id_pc, 32'h100);
      end
      finish_cycle();
    end
    chk("inflight_first_seen", 32'(found), 32'h1);

    // Redirect coinciding with a response and a pop.
    do_reset();
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    settle();
    chk("coinc_head_valid", 32'(id_valid), 32'h1);
    chk("coinc_head_pc",    id_pc,         32'h0);
    finish_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("coinc_empty",  32'(id_valid), 32'h0);
    chk("coinc_iaddr",  iaddr,         32'h100);
    finish_cycle();
    settle();
    chk("coinc_no_early_valid", 32'(id_valid), 32'h0);
    finish_cycle();
    settle();
    chk("coinc_first_pc",    id_pc,    32'h100);
    chk("coinc_first_instr", id_instr, mem_word(32'h100));
    finish_cycle();

    // Reset with a full queue: outputs drop before any clock edge.
    do_reset();
    id_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1;
    settle();
    chk("midrst_ireq",     32'(ireq),     32'h0);
    chk("midrst_id_valid", 32'(id_valid), 32'h0);
    chk("midrst_id_pc",    id_pc,         32'h0);
    chk("midrst_id_instr", id_instr,      32'h0);
    finish_cycle();
    reset = 1'b0; id_ready = 1'b1;
    settle();
    chk("midrst_restart_iaddr", iaddr,     RESET_PC);
    chk("midrst_restart_ireq",  32'(ireq), 32'h1);
    finish_cycle();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      settle();
      if (id_valid) begin
        found = 1'b1;
        chk("midrst_first_pc", id_pc, RESET_PC);
      end
      finish_cycle();
    end
    chk("midrst_first_seen", 32'(found), 32'h1);

    // Randomized traffic against the reference model.
    lat_min = 1; lat_max = 4;
    for (int c = 0; c < 800; c++) begin
      reset          = ($urandom_range(249, 0) == 0);
      iready         = ($urandom_range(9, 0) < 7);
      id_ready       = ($urandom_range(9, 0) < 6);
      redirect_valid = ($urandom_range(24, 0) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      mem_hold       = ($urandom_range(9, 0) < 2);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
